// File: rtl/mac_stream_sender_if.sv
// MAC input-side link: operand burst towards the MAC, result/done strobes back.
// master = mac_stream_sender, slave = MAC controller.
interface mac_stream_sender_if #(
    parameter int DATA_W = 16
);
    logic              mode;
    logic              valid_in;
    logic              last_in;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              done;

    modport master (
        output mode, valid_in, last_in, data_out,
        input  valid_out, done
    );

    modport slave (
        input  mode, valid_in, last_in, data_out,
        output valid_out, done
    );
endinterface

// File: rtl/mac_stream_sender.sv
// Buffers host operands in a FIFO and bursts them into the MAC, then retires the burst.
// Optional build macro WAIT_WATCHDOG_EN bounds the WAIT state to TIMEOUT cycles.
module mac_stream_sender #(
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 16,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                full,
    output logic                ovf,
    input  logic                start,
    input  logic                start_mode,
    input  logic [LEN_W-1:0]    start_len,
    output logic                busy,
    output logic                burst_done,
    output logic                timeout,
    mac_stream_sender_if.master mac
);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
        $error("mac_stream_sender: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_e;

    state_e            state_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q;
    logic              ovf_q;
    logic              mode_q;
    logic [LEN_W-1:0]  len_q, sent_q, sent_d, res_q;
    logic              valid_q, last_q, done_q;
    logic [DATA_W-1:0] data_q;
    logic              push, pop, empty, last_pop, complete;

    always_comb begin
        full     = (count_q == (AW+1)'(DEPTH));
        empty    = (count_q == '0);
        push     = wr_en && !full;
        pop      = (state_q == SEND) && !empty && (sent_q != len_q);
        sent_d   = sent_q + LEN_W'(1);
        last_pop = pop && (sent_d == len_q);
        complete = (state_q == WAIT) && (mode_q ? mac.done : (res_q == len_q));
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_data;
    end

    // Operand FIFO; a write while full is dropped and latches ovf.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)      count_q <= count_q + (AW+1)'(1);
            else if (pop && !push) count_q <= count_q - (AW+1)'(1);
            if (wr_en && full) ovf_q <= 1'b1;
        end
    end

`ifdef WAIT_WATCHDOG_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_q;
    logic          timeout_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            len_q   <= '0;
            sent_q  <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
`ifdef WAIT_WATCHDOG_EN
            wait_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            valid_q <= pop;
            last_q  <= last_pop;
            done_q  <= 1'b0;
            if (pop) data_q <= mem[rd_ptr_q];
            if (state_q != IDLE && !mode_q && mac.valid_out && res_q != len_q)
                res_q <= res_q + LEN_W'(1);

            case (state_q)
                IDLE: begin
                    if (start && start_len != '0) begin
                        state_q <= SEND;
                        mode_q  <= start_mode;
                        len_q   <= start_len;
                        sent_q  <= '0;
                        res_q   <= '0;
                    end else begin
                        // mode is kept through the burst_done cycle, dropped after it
                        mode_q <= 1'b0;
                    end
                end
                SEND: begin
                    if (pop) begin
                        sent_q <= sent_d;
                        if (last_pop) begin
                            state_q <= WAIT;
`ifdef WAIT_WATCHDOG_EN
                            wait_q  <= '0;
`endif
                        end
                    end
                end
                WAIT: begin
                    if (complete) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
`ifdef WAIT_WATCHDOG_EN
                    else if (wait_q == TW'(TIMEOUT - 1)) begin
                        state_q   <= IDLE;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + TW'(1);
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ovf          = ovf_q;
    assign busy         = (state_q != IDLE);
    assign burst_done   = done_q;
    assign mac.mode     = mode_q;
    assign mac.valid_in = valid_q;
    assign mac.last_in  = last_q;
    assign mac.data_out = data_q;
`ifdef WAIT_WATCHDOG_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif
endmodule
